// File: rtl/mod_sched.sv
// mod_sched: two-requester round-robin scheduler that sequences an external
// iterative-subtraction modulo datapath and returns a mod b per request.
// Optional feature macro: MOD_SCHED_ITER_LIMIT_EN caps the number of
// subtractions at MAX_ITER and flags the result as an error when hit.
module mod_sched #(
  parameter int unsigned MAX_ITER = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [1:0]  dp_state,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  input  logic [31:0] dp_temp,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_err
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, SUB, RESP} state_t;
  typedef enum logic [1:0] {
    DP_INIT = 2'd0,
    DP_SUB  = 2'd1,
    DP_CMP  = 2'd2,
    DP_DONE = 2'd3
  } dp_cmd_t;

  state_t      state_q, state_d;
  dp_cmd_t     dp_state_q, dp_state_d;
  logic        last_q, last_d;
  logic [31:0] dp_a_q, dp_a_d;
  logic [31:0] dp_b_q, dp_b_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_result_q, resp_result_d;
  logic        resp_err_q, resp_err_d;

  logic        grant0, grant1;
  logic        sel;
  logic [31:0] a_in, b_in;
  logic        temp_ge_b;

`ifdef MOD_SCHED_ITER_LIMIT_EN
  logic [31:0] cnt_q, cnt_d;
`else
  logic        unused_max_iter;
  assign unused_max_iter = ^MAX_ITER;
`endif

  assign dp_state    = dp_state_q;
  assign dp_a        = dp_a_q;
  assign dp_b        = dp_b_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_q);
    grant1     = req1_valid & (~req0_valid | ~last_q);
    req0_ready = (state_q == IDLE) & grant0;
    req1_ready = (state_q == IDLE) & grant1;
  end

  // Next-state logic; dp_state is derived from the next state so the
  // registered command lines up with the state it belongs to.
  always_comb begin
    state_d       = state_q;
    dp_state_d    = dp_state_q;
    last_d        = last_q;
    dp_a_d        = dp_a_q;
    dp_b_d        = dp_b_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    sel           = req1_ready;
    a_in          = req1_ready ? req1_a : req0_a;
    b_in          = req1_ready ? req1_b : req0_b;
    temp_ge_b     = (dp_temp >= dp_b_q);
`ifdef MOD_SCHED_ITER_LIMIT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          dp_a_d    = a_in;
          dp_b_d    = b_in;
          resp_id_d = sel;
          last_d    = sel;
          if (b_in == '0) begin
            // Divide-by-zero: answer immediately, datapath stays in COMPARE.
            state_d       = RESP;
            dp_state_d    = DP_CMP;
            resp_valid_d  = 1'b1;
            resp_result_d = '0;
            resp_err_d    = 1'b1;
          end else begin
            state_d    = LOAD;
            dp_state_d = DP_INIT;
          end
        end
      end
      LOAD: begin
        state_d    = CHECK;
        dp_state_d = DP_CMP;
`ifdef MOD_SCHED_ITER_LIMIT_EN
        cnt_d      = '0;
`endif
      end
      CHECK: begin
`ifdef MOD_SCHED_ITER_LIMIT_EN
        if (temp_ge_b && (cnt_q == MAX_ITER)) begin
          state_d       = RESP;
          dp_state_d    = DP_DONE;
          resp_valid_d  = 1'b1;
          resp_result_d = dp_temp;
          resp_err_d    = 1'b1;
        end else
`endif
        if (temp_ge_b) begin
          state_d    = SUB;
          dp_state_d = DP_SUB;
        end else begin
          state_d       = RESP;
          dp_state_d    = DP_DONE;
          resp_valid_d  = 1'b1;
          resp_result_d = dp_temp;
          resp_err_d    = 1'b0;
        end
      end
      SUB: begin
        state_d    = CHECK;
        dp_state_d = DP_CMP;
`ifdef MOD_SCHED_ITER_LIMIT_EN
        cnt_d      = cnt_q + 32'd1;
`endif
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          dp_state_d   = DP_CMP;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        dp_state_d   = DP_CMP;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset wins over any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dp_state_q    <= DP_CMP;
      last_q        <= 1'b1;
      dp_a_q        <= '0;
      dp_b_q        <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
`ifdef MOD_SCHED_ITER_LIMIT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      dp_state_q    <= dp_state_d;
      last_q        <= last_d;
      dp_a_q        <= dp_a_d;
      dp_b_q        <= dp_b_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
`ifdef MOD_SCHED_ITER_LIMIT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/mod_sched.md
MOD_SCHED -- requirements
Module: mod_sched

Interface
REQ-001 Parameter: MAX_ITER, default 1024, subtraction cap used only when MOD_SCHED_ITER_LIMIT_EN is defined.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req0_valid / req1_valid  input  1 each  requester has an operand pair pending.
REQ-005 Port: req0_ready / req1_ready  output  1 each  request accepted this cycle (valid & ready = acceptance).
REQ-006 Port: req0_a, req0_b, req1_a, req1_b  input  32 each  dividend / modulus, unsigned.
REQ-007 Port: dp_state  output  2  datapath command: 0 INITIALIZE, 1 SUBTRACT, 2 COMPARE (hold), 3 DONE (hold).
REQ-008 Port: dp_a, dp_b  output  32 each  latched operands of the job in service, to datapath.
REQ-009 Port: dp_temp  input  32  datapath running remainder.
REQ-010 Port: resp_valid  output  1  result available; resp_ready  input  1  consumer accepts.
REQ-011 Port: resp_id  output  1  requester index of the result; resp_result  output  32  a mod b; resp_err  output  1  error flag.

Function
REQ-012 States IDLE, LOAD, CHECK, SUB, RESP; dp_state = COMPARE in IDLE/CHECK, INITIALIZE in LOAD, SUBTRACT in SUB, DONE in RESP.
REQ-013 IDLE: ready asserted (combinationally) only to the granted requester; both ready never high together; no ready outside IDLE.
REQ-014 Arbitration round-robin: one valid -> grant it; both valid -> grant the index not served last; last-served pointer updates on acceptance.
REQ-015 On acceptance (edge N) latch a, b, id; b != 0 -> LOAD; b == 0 -> RESP with resp_err=1, resp_result=0, datapath never commanded out of COMPARE.
REQ-016 LOAD lasts one cycle, then CHECK.
REQ-017 CHECK: dp_temp >= dp_b -> SUB; else -> RESP with resp_result <= dp_temp, resp_err=0.
REQ-018 SUB lasts one cycle, then CHECK; comparison unsigned 32-bit.
REQ-019 Latency: first resp_valid cycle = N+3+2*floor(a/b) for b != 0; N+1 for b == 0.
REQ-020 RESP: resp_valid, resp_id, resp_result, resp_err held stable until resp_valid & resp_ready, then IDLE next cycle; a new acceptance earliest the cycle after leaving RESP.
REQ-021 Requests arriving during a job are held off (ready low) and not lost; requester must keep valid and operands stable until accepted.
REQ-022 a == 0 or a < b: zero subtractions, result = a; a == b: one subtraction, result 0; a = 0xFFFFFFFF, b = 1: correct with 2^32-1 subtractions (no counter wrap affects result).

Reset
REQ-023 rst high at an edge: state IDLE, resp_valid=0, resp_id=0, resp_result=0, resp_err=0, dp_state=COMPARE, dp_a=dp_b=0, last-served pointer=1 (req0 wins first tie).
REQ-024 rst mid-job aborts it: no response is produced for the aborted job; requester must re-issue.
REQ-025 rst during RESP drops resp_valid the next cycle regardless of resp_ready.

Configuration
REQ-026 Macro MOD_SCHED_ITER_LIMIT_EN defined: subtraction counter (cleared in LOAD, +1 per SUB); in CHECK, if count == MAX_ITER and dp_temp >= dp_b -> RESP with resp_err=1, resp_result=dp_temp.
REQ-027 Macro undefined: no counter, no iteration limit; resp_err asserted only for b == 0.

Verification
REQ-028 req0 a=17 b=5 only, resp_ready=1 -> resp_valid at N+9, resp_id=0, resp_result=2, resp_err=0.
REQ-029 req0 and req1 valid together from reset (a=10 b=3, a=9 b=4) -> req0 served first (result 1), then req1 (result 1); next tie goes to req0 again.
REQ-030 req1 a=7 b=0 -> resp_valid at N+1, resp_err=1, resp_result=0, dp_state stays 2 throughout.
REQ-031 a=4 b=9, resp_ready low 5 cycles -> resp_valid at N+3, result 4 held stable until handshake, IDLE next cycle.
REQ-032 rst asserted in SUB of job a=100 b=7 -> next cycle IDLE, resp_valid=0, dp_state=2, no response emitted.
REQ-033 With MOD_SCHED_ITER_LIMIT_EN, MAX_ITER=4, a=100 b=7 -> resp_err=1, resp_result=72; without macro -> resp_err=0, resp_result=2.
